// File: rtl/harris_corner_nms.sv
// Harris corner non-maximum suppression over a raster stream of response samples.
// Surviving 3x3 local maxima are queued as {x, y, score} keypoints in a FWFT FIFO.
module harris_corner_nms #(
   parameter  int ImageW    = 640,
   parameter  int ImageH    = 480,
   parameter  int dataW     = 8,
   parameter  int FifoDepth = 16,
   localparam int XW        = $clog2(ImageW),
   localparam int YW        = $clog2(ImageH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             frameStart,
   input  logic [dataW-1:0] respIn,
   input  logic [dataW-1:0] threshold,
   input  logic             kpReady,
   output logic             kpValid,
   output logic [XW-1:0]    kpX,
   output logic [YW-1:0]    kpY,
   output logic [dataW-1:0] kpScore,
   output logic             overflow,
   output logic [15:0]      dropCount
);
   localparam int AW = $clog2(FifoDepth);

   typedef struct packed {
      logic [XW-1:0]    x;
      logic [YW-1:0]    y;
      logic [dataW-1:0] score;
   } kp_t;

   logic [XW-1:0] x, cx;
   logic [YW-1:0] y, cy;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cx = x;
      cy = y;
      if (frameStart) begin
         cx = '0;
         cy = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         // NOTE: state uses non-blocking assignment so every always_ff sees pre-edge values.
         if (cx == XW'(ImageW - 1)) begin
            x <= '0;
            y <= (cy == YW'(ImageH - 1)) ? '0 : cy + 1'b1;
         end else begin
            x <= cx + 1'b1;
            y <= cy;
         end
      end
   end

   // lb1 holds row y-1 and lb2 holds row y-2, both indexed by the current column.
   logic [dataW-1:0]      lb1 [ImageW];
   logic [dataW-1:0]      lb2 [ImageW];
   logic [2:0][dataW-1:0] c1, c2, nc;

   always_ff @(posedge clk) begin
      // NOTE: line buffers carry no reset; the y>=2 gate keeps stale rows out of any decision.
      if (en) begin
         lb1[cx] <= respIn;
         lb2[cx] <= lb1[cx];
      end
   end

   // Window rows: index 0 = y-2, 1 = y-1 (centre row), 2 = y (incoming).
   always_comb nc = {respIn, lb1[cx], lb2[cx]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c1 <= '0;
         c2 <= '0;
      end else if (en) begin
         c2 <= c1;
         c1 <= nc;
      end
   end

   logic [dataW-1:0] centre;
   logic             is_peak;

   // Ties favour the later pixel, so a plateau reports only its last raster position.
   always_comb begin
      centre  = c1[1];
      is_peak = en && (cx >= XW'(2)) && (cy >= YW'(2)) && (centre > threshold)
             && (centre >= c2[0]) && (centre >= c1[0]) && (centre >= nc[0]) && (centre >= c2[1])
             && (centre >  nc[1]) && (centre >  c2[2]) && (centre >  c1[2]) && (centre >  nc[2]);
   end

   logic cand_valid;
   kp_t  cand;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_valid <= 1'b0;
         cand       <= '0;
      end else begin
         cand_valid <= is_peak;
         if (is_peak) cand <= '{x: XW'(cx - 1'b1), y: YW'(cy - 1'b1), score: centre};
      end
   end

   kp_t           mem [FifoDepth];
   kp_t           head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, push, drop;

   always_comb begin
      kpValid = (count != '0);
      full    = (count == (AW+1)'(FifoDepth));
      pop     = kpValid && kpReady;
      push    = cand_valid && (!full || pop);
      drop    = cand_valid && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cand;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         dropCount <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (dropCount != 16'hFFFF) dropCount <= dropCount + 1'b1;
         end
      end
   end

   // Head is masked while empty so reset and idle both present zeros.
   always_comb begin
      head    = mem[rd_ptr];
      kpX     = kpValid ? head.x     : '0;
      kpY     = kpValid ? head.y     : '0;
      kpScore = kpValid ? head.score : '0;
   end

endmodule

// File: tb/tb_harris_corner_nms.sv
// Directed bench for harris_corner_nms: a frame-level NMS model predicts the keypoint
// stream, and one per-cycle compare process checks every pop and every stalled cycle.
module tb_harris_corner_nms;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int D  = 16;
   localparam int DW = 8;
   localparam int THR = 10;

   logic          clk = 1'b0;
   logic          rst, en, frameStart, kpReady, kpValid, overflow;
   logic [DW-1:0] respIn, threshold, kpScore;
   logic [2:0]    kpX, kpY;
   logic [15:0]   dropCount;

   always #5 clk = ~clk;

   harris_corner_nms #(.ImageW(W), .ImageH(H), .dataW(DW), .FifoDepth(D)) dut (
      .clk(clk), .rst(rst), .en(en), .frameStart(frameStart), .respIn(respIn),
      .threshold(threshold), .kpReady(kpReady), .kpValid(kpValid), .kpX(kpX),
      .kpY(kpY), .kpScore(kpScore), .overflow(overflow), .dropCount(dropCount)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          img [H][W];
   logic [13:0] exp_q [$];
   int          exp_drops;
   int          n_pop;
   logic [13:0] last_kp;
   int          mark_cyc, rise_cyc;
   bit          rise_seen;
   bit          toggle_mode;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [13:0] pack(input int px, input int py, input int ps);
      return {px[2:0], py[2:0], ps[7:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic clear_img();
      foreach (img[i, j]) img[i][j] = 0;
   endtask

   // Scan every interior centre of the frame and apply the raster-ordered tie rule.
   task automatic model_frame(input bit stalled);
      for (int py = 1; py < H - 1; py++) begin
         for (int px = 1; px < W - 1; px++) begin
            int c;
            bit ok;
            c  = img[py][px];
            ok = (c > THR);
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  int n;
                  if (dy == 0 && dx == 0) continue;
                  n = img[py+dy][px+dx];
                  if (dy < 0 || (dy == 0 && dx < 0)) ok = ok && (c >= n);
                  else                               ok = ok && (c > n);
               end
            end
            if (ok) begin
               if (stalled && exp_q.size() >= D) exp_drops++;
               else exp_q.push_back(pack(px, py, c));
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_frame(input int n_samples);
      for (int i = 0; i < n_samples; i++) begin
         int px, py;
         px = i % W;
         py = i / W;
         en = 1'b1;
         frameStart = (i == 0);
         respIn = DW'(img[py][px]);
         if (px == 4 && py == 3) mark_cyc = cyc;
         @(posedge clk);
         #1;
      end
      en = 1'b0;
      frameStart = 1'b0;
      respIn = '0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !kpValid) break;
      end
      check({name, "_pending"}, exp_q.size(), 0);
      check({name, "_idle"}, kpValid, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [13:0] prev_kp, cur;
      bit          stall_prev, prev_valid;
      stall_prev = 0;
      prev_valid = 0;
      forever begin
         @(negedge clk);
         cur = {kpX, kpY, kpScore};
         if (rst) begin
            stall_prev = 0;
            prev_valid = 0;
            continue;
         end
         if (stall_prev) begin
            check("stall_valid", kpValid, 1);
            check("stall_data", cur, prev_kp);
         end
         if (kpValid && !prev_valid && !rise_seen) begin
            rise_seen = 1;
            rise_cyc  = cyc;
         end
         if (kpValid && kpReady) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_kp: got %0d expected none", cur);
            end else begin
               check("kp", cur, exp_q.pop_front());
            end
            n_pop++;
            last_kp = cur;
         end
         stall_prev = kpValid && !kpReady;
         prev_kp    = cur;
         prev_valid = kpValid;
      end
   end

   initial begin
      toggle_mode = 0;
      forever begin
         @(posedge clk);
         #1;
         if (toggle_mode) kpReady = ~kpReady;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n0;
      rst = 1'b1; en = 1'b0; frameStart = 1'b0; respIn = '0; threshold = DW'(THR);
      kpReady = 1'b1; exp_drops = 0; n_pop = 0; rise_seen = 0; mark_cyc = 0; rise_cyc = 0;
      #1;
      check("rst_kpValid", kpValid, 0);
      check("rst_kpX", kpX, 0);
      check("rst_kpY", kpY, 0);
      check("rst_kpScore", kpScore, 0);
      check("rst_overflow", overflow, 0);
      check("rst_dropCount", dropCount, 0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;

      // Single peak, plus output latency from the sample that completes its window.
      clear_img();
      img[2][3] = 100;
      model_frame(0);
      check("model_single_n", exp_q.size(), 1);
      check("model_single_kp", exp_q[0], pack(3, 2, 100));
      rise_seen = 0;
      n0 = n_pop;
      run_frame(W * H);
      idle(6);
      wait_drain("single");
      check("single_count", n_pop - n0, 1);
      check("single_kp", last_kp, pack(3, 2, 100));
      check("single_latency", rise_cyc - mark_cyc, 2);

      // Two-pixel plateau: only the later pixel survives.
      clear_img();
      img[2][3] = 50;
      img[2][4] = 50;
      model_frame(0);
      check("model_plateau_n", exp_q.size(), 1);
      check("model_plateau_kp", exp_q[0], pack(4, 2, 50));
      n0 = n_pop;
      run_frame(W * H);
      idle(6);
      wait_drain("plateau");
      check("plateau_count", n_pop - n0, 1);
      check("plateau_kp", last_kp, pack(4, 2, 50));

      // Equal-to-threshold peak, then peaks on the frame border.
      n0 = n_pop;
      clear_img();
      img[2][3] = 10;
      model_frame(0);
      check("model_thresh_n", exp_q.size(), 0);
      run_frame(W * H);
      idle(4);
      clear_img();
      img[2][0] = 200;
      img[3][7] = 200;
      model_frame(0);
      check("model_border_n", exp_q.size(), 0);
      run_frame(W * H);
      idle(6);
      wait_drain("reject");
      check("reject_count", n_pop - n0, 0);

      // Stalled consumer: 20 isolated peaks over four frames overfill the FIFO.
      kpReady = 1'b0;
      for (int f = 0; f < 4; f++) begin
         clear_img();
         img[1][1] = 100; img[1][3] = 100; img[1][5] = 100;
         img[3][1] = 100; img[3][3] = 100;
         model_frame(1);
         run_frame(W * H);
         idle(2);
      end
      check("model_stall_held", exp_q.size(), 16);
      check("model_stall_drops", exp_drops, 4);
      idle(4);
      check("stall_valid_full", kpValid, 1);
      check("stall_dropCount", dropCount, exp_drops);
      check("stall_overflow", overflow, 1);
      n0 = n_pop;
      kpReady = 1'b1;
      wait_drain("stall");
      check("stall_count", n_pop - n0, 16);

      // Ready toggling every cycle while six peaks stream.
      clear_img();
      img[1][1] = 100; img[1][3] = 120; img[1][5] = 140;
      img[3][1] = 160; img[3][3] = 180; img[3][5] = 200;
      model_frame(0);
      check("model_toggle_n", exp_q.size(), 6);
      n0 = n_pop;
      toggle_mode = 1;
      run_frame(W * H);
      idle(6);
      wait_drain("toggle");
      toggle_mode = 0;
      #1 kpReady = 1'b1;
      check("toggle_count", n_pop - n0, 6);
      check("sticky_dropCount", dropCount, 4);
      check("sticky_overflow", overflow, 1);

      // Reset in row 3 with a keypoint waiting, then a clean frame.
      kpReady = 1'b0;
      clear_img();
      img[2][3] = 100;
      model_frame(0);
      run_frame(3 * W + 6);
      check("prerst_valid", kpValid, 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_kpValid", kpValid, 0);
      check("midrst_kpX", kpX, 0);
      check("midrst_kpY", kpY, 0);
      check("midrst_kpScore", kpScore, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_dropCount", dropCount, 0);
      exp_q.delete();
      exp_drops = 0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      kpReady = 1'b1;
      model_frame(0);
      n0 = n_pop;
      run_frame(W * H);
      idle(6);
      wait_drain("after_rst");
      check("after_rst_count", n_pop - n0, 1);
      check("after_rst_kp", last_kp, pack(3, 2, 100));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
